// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one byte out and checks the ACK.
// Optional build macro PS2_TX_RESEND_EN retries a failed byte up to two more times before reporting an error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]  INH_ONE   = INH_W'(1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TOUT_W-1:0] TOUT_ONE  = TOUT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t            state_r;
  logic              tx_ready_r, cdl_r, ddl_r, rx_inhibit_r, tx_done_r, tx_error_r;
  logic [INH_W-1:0]  inh_cnt_r;
  logic [TOUT_W-1:0] tout_cnt_r;
  logic [3:0]        bit_idx_r;
  logic [7:0]        byte_r;
  logic              parity_r, ack_r;
  logic              clk_meta_r, clk_sync_r, clk_prev_r, dat_meta_r, dat_sync_r;
  logic              clk_fall_s, timed_s, timeout_s, lines_idle_s, fail_s;
`ifdef PS2_TX_RESEND_EN
  logic [1:0]        retry_cnt_r;
`endif

  // Synchronize both asynchronous bus lines and keep one older clock sample for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clock_in;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= ps2_data_in;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign clk_fall_s   = clk_prev_r & ~clk_sync_r;
  assign lines_idle_s = clk_sync_r & dat_sync_r;
  assign timed_s      = (state_r == REQ) || (state_r == SEND) || (state_r == ACK) || (state_r == WAIT_IDLE);
  assign timeout_s    = timed_s && (tout_cnt_r == TOUT_LAST);
  // A NACK only counts as a failure once the device has released the bus.
  assign fail_s       = timeout_s || ((state_r == WAIT_IDLE) && lines_idle_s && !ack_r);

  // Transmit sequencer: frame timing, line drives, timeout and completion pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      tx_ready_r   <= 1'b1;
      cdl_r        <= 1'b0;
      ddl_r        <= 1'b0;
      rx_inhibit_r <= 1'b0;
      tx_done_r    <= 1'b0;
      tx_error_r   <= 1'b0;
      inh_cnt_r    <= {INH_W{1'b0}};
      tout_cnt_r   <= {TOUT_W{1'b0}};
      bit_idx_r    <= 4'd0;
      byte_r       <= 8'h00;
      parity_r     <= 1'b0;
      ack_r        <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_cnt_r  <= 2'd0;
`endif
    end else begin
      tx_done_r  <= 1'b0;
      tx_error_r <= 1'b0;
      if (timed_s) begin
        tout_cnt_r <= tout_cnt_r + TOUT_ONE;
      end
      if (fail_s) begin
`ifdef PS2_TX_RESEND_EN
        if (retry_cnt_r != 2'd2) begin
          retry_cnt_r <= retry_cnt_r + 2'd1;
          inh_cnt_r   <= {INH_W{1'b0}};
          cdl_r       <= 1'b1;
          ddl_r       <= 1'b0;
          state_r     <= INHIBIT;
        end else begin
          cdl_r        <= 1'b0;
          ddl_r        <= 1'b0;
          tx_error_r   <= 1'b1;
          tx_ready_r   <= 1'b1;
          rx_inhibit_r <= 1'b0;
          state_r      <= IDLE;
        end
`else
        cdl_r        <= 1'b0;
        ddl_r        <= 1'b0;
        tx_error_r   <= 1'b1;
        tx_ready_r   <= 1'b1;
        rx_inhibit_r <= 1'b0;
        state_r      <= IDLE;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (tx_valid) begin
              byte_r       <= tx_data;
              parity_r     <= odd_parity(tx_data);
              inh_cnt_r    <= {INH_W{1'b0}};
              cdl_r        <= 1'b1;
              tx_ready_r   <= 1'b0;
              rx_inhibit_r <= 1'b1;
              state_r      <= INHIBIT;
`ifdef PS2_TX_RESEND_EN
              retry_cnt_r  <= 2'd0;
`endif
            end
          end
          INHIBIT: begin
            if (inh_cnt_r == INH_LAST) begin
              cdl_r      <= 1'b0;
              ddl_r      <= 1'b1;
              tout_cnt_r <= {TOUT_W{1'b0}};
              state_r    <= REQ;
            end else begin
              inh_cnt_r <= inh_cnt_r + INH_ONE;
            end
          end
          REQ: begin
            if (clk_fall_s) begin
              ddl_r     <= ~byte_r[0];
              bit_idx_r <= 4'd1;
              state_r   <= SEND;
            end
          end
          SEND: begin
            // Index 1..7 data, 8 parity, 9 stop (line released).
            if (clk_fall_s) begin
              if (bit_idx_r < 4'd8) begin
                ddl_r <= ~byte_r[bit_idx_r[2:0]];
              end else if (bit_idx_r == 4'd8) begin
                ddl_r <= ~parity_r;
              end else begin
                ddl_r   <= 1'b0;
                state_r <= ACK;
              end
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
          ACK: begin
            if (clk_fall_s) begin
              ack_r   <= ~dat_sync_r;
              state_r <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (lines_idle_s) begin
              tx_done_r    <= 1'b1;
              tx_ready_r   <= 1'b1;
              rx_inhibit_r <= 1'b0;
              state_r      <= IDLE;
            end
          end
          default: begin
            cdl_r        <= 1'b0;
            ddl_r        <= 1'b0;
            tx_ready_r   <= 1'b1;
            rx_inhibit_r <= 1'b0;
            state_r      <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready            = tx_ready_r;
  assign ps2_clock_drive_low = cdl_r;
  assign ps2_data_drive_low  = ddl_r;
  assign rx_inhibit          = rx_inhibit_r;
  assign tx_done             = tx_done_r;
  assign tx_error            = tx_error_r;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: device BFM on an open-drain bus model, directed table plus randomized frames.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TOUT = 3000;
  localparam int HP   = 20;
  localparam int M_ACK = 0, M_NACK = 1, M_NOCLK = 2, M_RESET = 3;
`ifdef PS2_TX_RESEND_EN
  localparam int TRIES = 3;
`else
  localparam int TRIES = 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic       poke;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
    int         exp_frames;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, cdl, ddl, rx_inhibit, tx_done, tx_error;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_line, ps2_data_line;

  int n_checks = 0, n_fail = 0;
  int cyc_n = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, req_t = 0, err_t = 0;
  logic prev_cdl = 1'b0;
  vec_t vecs[$];

  assign ps2_clk_line  = dev_clk & ~cdl;
  assign ps2_data_line = dev_data & ~ddl;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clock_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clock_drive_low(cdl), .ps2_data_drive_low(ddl),
    .rx_inhibit(rx_inhibit), .tx_done(tx_done), .tx_error(tx_error)
  );

  // Event monitor: pulse counts, frame starts, and timestamps of REQ entry and error pulses
  always @(negedge clk) begin
    cyc_n    <= cyc_n + 1;
    prev_cdl <= cdl;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_t   <= cyc_n;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (cdl && !prev_cdl) inh_cnt <= inh_cnt + 1;
    if (!cdl && prev_cdl) req_t <= cyc_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Odd parity bit from a plain count of ones.
  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic vec_t model_vec(input logic [7:0] d, input int mode, input logic poke);
    vec_t v;
    v.data       = d;
    v.mode       = mode;
    v.poke       = poke;
    v.exp_par    = model_parity(d);
    v.exp_done   = (mode == M_ACK) ? 1 : 0;
    v.exp_err    = (mode == M_NACK || mode == M_NOCLK) ? 1 : 0;
    v.exp_frames = (mode == M_NACK || mode == M_NOCLK) ? TRIES : 1;
    return v;
  endfunction

  // One bus frame as seen by the device: inhibit length, start bit, clocking, captured bits
  task automatic frame(input vec_t v, input int f, output logic ok);
    int cnt;
    int nedge;
    logic [9:0] bits;
    ok = 1'b1;
    bits = 10'h000;
    cnt = 0;
    while (!cdl && cnt < 3 * TOUT) begin
      cyc(1);
      cnt++;
    end
    check("frame_start", 32'(cdl), 32'd1);
    if (!cdl) begin
      ok = 1'b0;
      return;
    end
    cnt = 0;
    while (cdl && cnt < 4 * INH) begin
      if (v.poke && f == 0 && cnt == 10) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end else begin
        tx_valid = 1'b0;
      end
      cyc(1);
      cnt++;
    end
    tx_valid = 1'b0;
    check("inhibit_len", 32'(cnt), 32'(INH));
    check("start_bit", 32'(ddl), 32'd1);
    check("rx_inhibit_busy", 32'(rx_inhibit), 32'd1);
    nedge = (v.mode == M_NOCLK) ? 0 : (v.mode == M_RESET) ? 4 : 11;
    for (int k = 1; k <= nedge; k++) begin
      if (k == 11) dev_data = (v.mode == M_ACK) ? 1'b0 : 1'b1;
      cyc(HP);
      dev_clk = 1'b0;
      cyc(HP);
      if (k <= 10) bits[k-1] = ps2_data_line;
      dev_clk = 1'b1;
    end
    if (nedge == 11) begin
      cyc(HP);
      dev_data = 1'b1;
      check("frame_bits", 32'(bits), 32'({1'b1, v.exp_par, v.data}));
    end
    if (v.mode == M_RESET) begin
      cyc(2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("rst_clk_rel", 32'(cdl), 32'd0);
      check("rst_dat_rel", 32'(ddl), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, i0, t, bound;
    logic ok;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    t = 0;
    while (!tx_ready && t < 200) begin
      cyc(1);
      t++;
    end
    check("ready_idle", 32'(tx_ready), 32'd1);
    tx_data  = v.data;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("ready_drop", 32'(tx_ready), 32'd0);
    ok = 1'b1;
    for (int f = 0; f < v.exp_frames && ok; f++) frame(v, f, ok);
    bound = (v.exp_done + v.exp_err > 0) ? 4 * TOUT : 60;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < bound) begin
      cyc(1);
      t++;
    end
    cyc(4);
    check("done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
    check("error_pulses", 32'(err_cnt - e0), 32'(v.exp_err));
    check("frames_seen", 32'(inh_cnt - i0), 32'(v.exp_frames));
    check("ready_after", 32'(tx_ready), 32'd1);
    check("lines_released", 32'({cdl, ddl}), 32'd0);
    check("rx_inhibit_idle", 32'(rx_inhibit), 32'd0);
    if (v.mode == M_NOCLK) check("timeout_len", 32'(err_t - req_t), 32'(TOUT));
  endtask

  initial begin
    vecs.push_back('{8'hED, M_ACK,   1'b1, 1'b1, 1, 0, 1});
    vecs.push_back('{8'h00, M_ACK,   1'b0, 1'b1, 1, 0, 1});
    vecs.push_back('{8'h01, M_ACK,   1'b0, 1'b0, 1, 0, 1});
    vecs.push_back('{8'hA5, M_NACK,  1'b0, 1'b1, 0, 1, TRIES});
    vecs.push_back('{8'h3C, M_NOCLK, 1'b0, 1'b1, 0, 1, TRIES});
    vecs.push_back('{8'hED, M_RESET, 1'b0, 1'b1, 0, 0, 1});
    vecs.push_back('{8'hFF, M_ACK,   1'b0, 1'b1, 1, 0, 1});
    for (int i = 0; i < 12; i++) begin
      vecs.push_back(model_vec(8'($urandom_range(0, 255)),
                               ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK,
                               1'($urandom_range(0, 1))));
    end

    reset = 1'b1;
    cyc(3);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_lines", 32'({cdl, ddl}), 32'd0);
    check("reset_rx_inhibit", 32'(rx_inhibit), 32'd0);
    check("reset_pulses", 32'({tx_done, tx_error}), 32'd0);
    reset = 1'b0;
    cyc(2);

    foreach (vecs[i]) run_vec(vecs[i]);

    check("done_error_exclusive", 32'(both_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction of the keyboard receive path in a51.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Drives the open-drain PS/2 clock and data lines through active-low drive enables; the top level ties each line to 'z' or '0'.
- Asserts rx_inhibit so the receive path ignores bus activity that this block generates.

Parameters:
INHIBIT_CYCLES, 5000, system clocks the PS/2 clock is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max system clocks from clock release to end of ACK (15 ms at 50 MHz)

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
tx_data  input  8  command byte
tx_valid  input  1  request; byte accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
ps2_clock_in  input  1  sampled PS/2 clock line, asynchronous
ps2_data_in  input  1  sampled PS/2 data line, asynchronous
ps2_clock_drive_low  output  1  1 = pull PS/2 clock low
ps2_data_drive_low  output  1  1 = pull PS/2 data low
rx_inhibit  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse: device ACKed
tx_error  output  1  one-cycle pulse: no ACK or timeout

Behaviour:
- Reset values, applied synchronously:
  - state = IDLE, tx_ready = 1.
  - Both drive_low = 0, rx_inhibit = 0, tx_done = 0, tx_error = 0.
  - All counters = 0.
- Both line inputs pass through 2-flop synchronizers. A falling edge is sync'd clock 1 -> 0 across consecutive samples.
- Accept: on tx_valid && tx_ready, latch tx_data. Latch parity = ~^tx_data (odd parity). Go to INHIBIT. tx_ready drops the next cycle.
- INHIBIT:
  - clock_drive_low = 1 for exactly INHIBIT_CYCLES cycles.
  - On the final cycle, set data_drive_low = 1 (start bit) and go to REQ.
- REQ:
  - clock_drive_low = 0, data_drive_low = 1.
  - Start timeout counter.
  - On a falling edge, drive bit0 and go to SEND with bit index 1.
- SEND: on each falling edge, present the next item:
  - bits 1..7, LSB first;
  - then parity;
  - then stop: data_drive_low = 0 (release);
  - then go to ACK.
  - Bit value 1 means data_drive_low = 0; bit value 0 means data_drive_low = 1.
  - Data changes only in the cycle after a detected falling edge.
- ACK:
  - On the next falling edge, sample sync'd data. 0 = ACK; 1 = NACK.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until sync'd clock and data are both 1.
  - Then pulse tx_done (ACK) or tx_error (NACK) and return to IDLE.
- Timeout:
  - Counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses tx_error and goes to IDLE.
  - Timeout has priority over a same-cycle edge.
- tx_valid while busy is ignored; no queueing.
- Total falling edges consumed per byte: 11.
- Reset mid-frame: both lines are released the cycle after reset is sampled, with no done or error pulse.
- tx_done and tx_error are never high together.

Optional Feature:
PS2_TX_RESEND_EN
- Defined:
  - On NACK or timeout, retry the same latched byte from INHIBIT, up to 2 retries.
  - tx_error pulses only after the third failure.
  - A 2-bit retry count clears on accept and on reset.
  - tx_done pulses once on the first successful ACK.
- Undefined:
  - First failure pulses tx_error immediately; no retry logic is synthesized.

Test Plan:
- Device BFM with 12.5 kHz clocks that ACKs. Send 0xED -> clock held low 5000 cycles; bits 1,0,1,1,0,1,1,1 then parity 1 and stop 1 on the data line; tx_done pulse ~1 cycle after the lines idle; tx_ready back to 1.
- Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0. Both ACKed, tx_done each time.
- BFM withholds the ACK (data high on the 11th edge) -> tx_error pulse, no tx_done. With PS2_TX_RESEND_EN, three full frames are seen before tx_error.
- BFM never clocks after release -> tx_error exactly TIMEOUT_CYCLES after entering REQ; both drive_low = 0.
- Assert reset after the 4th falling edge -> next cycle both drive_low = 0, tx_ready = 1, no pulses. A fresh 0xFF then completes with tx_done.
- tx_valid pulsed with 0x55 during a 0xED frame -> ignored; only 0xED appears on the bus.
